// File: rtl/poly_decim_combiner.sv
// Polyphase decimator combiner: sums four branch outputs once per DECIM strobes,
// rounds/shifts/saturates to OUT_W, and buffers results in a show-ahead FIFO.
module poly_decim_combiner #(
    parameter int IN_W       = 17,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 3,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  e0_in,
    input  logic signed [IN_W-1:0]  e1_in,
    input  logic signed [IN_W-1:0]  e2_in,
    input  logic signed [IN_W-1:0]  e3_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    sat_flag,
    output logic                    ovf_err
);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = AW + 1;
    localparam int PW   = IN_W + 1;
    // One bit wider than the bare four-way sum: the rounding constant on top of
    // four full-scale positive inputs would otherwise reach 2^(IN_W+1).
    localparam int SW   = IN_W + 3;
    localparam logic signed [SW-1:0] QMAX = (SW'(1) << (OUT_W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] QMIN = -(SW'(1) << (OUT_W - 1));

    logic [PH_W-1:0]         phase;
    logic                    capture;
    logic [2:1]              vld_pipe;
    logic signed [PW-1:0]    p0, p1;
    logic signed [SW-1:0]    sum, q;
    logic signed [OUT_W-1:0] res;
    logic                    clamp;

    assign capture = in_valid && (phase == PH_W'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            vld_pipe <= '0;
        end else begin
            if (in_valid)
                phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
            vld_pipe <= {vld_pipe[1], capture};
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            p0 <= {e0_in[IN_W-1], e0_in} + {e1_in[IN_W-1], e1_in};
            p1 <= {e2_in[IN_W-1], e2_in} + {e3_in[IN_W-1], e3_in};
        end
        if (vld_pipe[1])
            sum <= {{2{p0[PW-1]}}, p0} + {{2{p1[PW-1]}}, p1} + SW'(1 << (SHIFT - 1));
    end

    always_comb begin
        q     = sum >>> SHIFT;
        clamp = 1'b0;
        res   = q[OUT_W-1:0];
        if (q > QMAX) begin
            res   = QMAX[OUT_W-1:0];
            clamp = 1'b1;
        end else if (q < QMIN) begin
            res   = QMIN[OUT_W-1:0];
            clamp = 1'b1;
        end
    end

    logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic signed [OUT_W-1:0] last_q;
    logic                    full, pop, wr;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    assign wr        = vld_pipe[2] && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr] : last_q;

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_q   <= '0;
            sat_flag <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (out_valid)
                last_q <= mem[rd_ptr];
            if (vld_pipe[2] && clamp)
                sat_flag <= 1'b1;
            if (vld_pipe[2] && full && !pop)
                ovf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_poly_decim_combiner.sv
// Scoreboard bench for poly_decim_combiner: directed groups push hand-computed
// expected outputs; a negedge monitor pops and compares on every handshake.
module tb_poly_decim_combiner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [16:0] e0 = '0, e1 = '0, e2 = '0, e3 = '0;
    logic out_valid, sat_flag, ovf_err;
    logic signed [15:0] out_data;

    int checks = 0;
    int failures = 0;
    int tb_phase = 0;
    logic signed [15:0] sb [$];
    logic hold_vld = 1'b0;
    logic signed [15:0] hold_data = '0;

    poly_decim_combiner dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .e0_in(e0), .e1_in(e1), .e2_in(e2), .e3_in(e3),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops on handshake, also checks data stays put under backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_vld = 1'b0;
            end else begin
                if (hold_vld) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, hold_data);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out: got %0d expected no output", out_data);
                    end else begin
                        check("out_data", out_data, sb.pop_front());
                    end
                end
                hold_vld  = out_valid && !out_ready;
                hold_data = out_data;
            end
        end
    end

    task automatic strobe(input int a, input int b, input int c, input int d,
                          input int exp, input bit push, input int gap);
        e0 = 17'(a); e1 = 17'(b); e2 = 17'(c); e3 = 17'(d);
        in_valid = 1'b1;
        if (tb_phase == 3 && push)
            sb.push_back(16'(exp));
        tb_phase = (tb_phase + 1) % 4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic group(input int a, input int b, input int c, input int d,
                         input int exp, input bit push, input int gap);
        for (int i = 0; i < 4; i++)
            strobe(a, b, c, d, exp, push, gap);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        cycles(2);
        rst = 1'b0;
        sb.delete();
        tb_phase = 0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_remaining", sb.size(), 0);
        check("empty_after_drain", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_ovf", ovf_err, 0);

        // Basic: 500 per group, latency 2 edges after the capture edge
        out_ready = 1'b1;
        group(1000, 1000, 1000, 1000, 500, 1'b1, 0);
        check("lat_edge0", out_valid, 0);
        cycles(1);
        check("lat_edge1", out_valid, 0);
        cycles(1);
        check("lat_edge2", out_valid, 1);
        group(1000, 1000, 1000, 1000, 500, 1'b1, 0);
        group(1000, 1000, 1000, 1000, 500, 1'b1, 0);
        wait_drain(20);
        check("basic_sat", sat_flag, 0);

        // Rounding
        group(6, 6, 0, 0, 2, 1'b1, 0);
        group(5, 6, 0, 0, 1, 1'b1, 0);
        group(-6, -6, 0, 0, -1, 1'b1, 0);
        wait_drain(20);

        // Saturation
        group(65535, 65535, 65535, 65535, 32767, 1'b1, 0);
        wait_drain(20);
        check("sat_set", sat_flag, 1);
        do_reset();
        check("sat_cleared", sat_flag, 0);
        group(-65536, -65536, -65536, -65536, -32768, 1'b1, 0);
        wait_drain(20);
        check("neg_exact_no_sat", sat_flag, 0);

        // Backpressure: 4 stored, 5th and 6th dropped
        do_reset();
        out_ready = 1'b0;
        for (int v = 10; v < 14; v++)
            group(4 * v, 4 * v, 0, 0, v, 1'b1, 0);
        cycles(3);
        check("bp_ovf_before", ovf_err, 0);
        check("bp_valid", out_valid, 1);
        group(56, 56, 0, 0, 14, 1'b0, 0);
        group(60, 60, 0, 0, 15, 1'b0, 0);
        cycles(3);
        check("bp_ovf_after", ovf_err, 1);
        out_ready = 1'b1;
        wait_drain(20);
        check("bp_ovf_sticky", ovf_err, 1);

        // Full FIFO + pop on the write edge: nothing dropped
        do_reset();
        out_ready = 1'b0;
        for (int v = 20; v < 24; v++)
            group(4 * v, 4 * v, 0, 0, v, 1'b1, 0);
        cycles(3);
        group(96, 96, 0, 0, 24, 1'b1, 0);
        cycles(1);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        check("fullpop_ovf", ovf_err, 0);
        check("fullpop_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_drain(20);
        check("fullpop_ovf_end", ovf_err, 0);

        // Gapped strobes
        do_reset();
        out_ready = 1'b1;
        group(120, 120, 0, 0, 30, 1'b1, int'($urandom_range(0, 3)));
        group(124, 124, 0, 0, 31, 1'b1, int'($urandom_range(0, 3)));
        group(128, 128, 0, 0, 32, 1'b1, int'($urandom_range(0, 3)));
        wait_drain(40);

        // Mid-run reset with 2 buffered and 1 in flight
        out_ready = 1'b0;
        group(160, 160, 0, 0, 40, 1'b1, 0);
        group(164, 164, 0, 0, 41, 1'b1, 0);
        cycles(3);
        group(168, 168, 0, 0, 42, 1'b1, 0);
        rst = 1'b1;
        cycles(1);
        check("midrst_valid", out_valid, 0);
        rst = 1'b0;
        sb.delete();
        tb_phase = 0;
        out_ready = 1'b1;
        cycles(5);
        check("midrst_no_stale", out_valid, 0);

        // Phase restarts at 0: two strobes, reset, then only the 4th strobe captures
        strobe(8, 8, 0, 0, 0, 1'b0, 0);
        strobe(8, 8, 0, 0, 0, 1'b0, 0);
        do_reset();
        for (int i = 0; i < 3; i++)
            strobe(172, 172, 0, 0, 43, 1'b1, 0);
        cycles(4);
        check("phase_no_early", out_valid, 0);
        strobe(172, 172, 0, 0, 43, 1'b1, 0);
        wait_drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
